// File: rtl/sigdel_pkg.sv
// rtl/sigdel_pkg.sv - shared state codes, widths and sample-word helpers for the sigdel event builder
package sigdel_pkg;

    localparam logic [1:0] ST_IDLE   = 2'd0;
    localparam logic [1:0] ST_ACTIVE = 2'd1;
    localparam logic [1:0] ST_QUIET  = 2'd2;

    localparam int PERIOD_BITS = 48;
    localparam int STAT_BITS   = 16;

    function automatic logic [5:0] popcount32(input logic [31:0] v);
        logic [5:0] n;
        n = '0;
        for (int i = 0; i < 32; i++) begin
            n = n + {5'd0, v[i]};
        end
        return n;
    endfunction

    // Bit spc-1 is the earliest sample, so the fine time is the distance of
    // the highest set bit from the top of the word.
    function automatic logic [4:0] fine_index(input logic [31:0] v, input int spc);
        logic [4:0] f;
        f = '0;
        for (int i = 0; i < 32; i++) begin
            if (i < spc && v[i]) begin
                f = 5'(spc - 1 - i);
            end
        end
        return f;
    endfunction

endpackage

// File: rtl/sigdel_event_fifo.sv
// rtl/sigdel_event_fifo.sv - first-word-fall-through event buffer with simultaneous push/pop
module sigdel_event_fifo
    import sigdel_pkg::*;
#(
    parameter int WIDTH = 176,
    parameter int DEPTH = 4,
    localparam int AW   = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    output logic [WIDTH-1:0] pop_data,
    output logic             full,
    output logic             empty
);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic [AW:0]      count;
    logic             push_ok;
    logic             pop_ok;

    assign full     = (count == (AW+1)'(DEPTH));
    assign empty    = (count == '0);
    assign pop_ok   = pop && !empty;
    assign push_ok  = push && (!full || pop_ok);
    assign pop_data = empty ? '0 : mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (push_ok) begin
            mem[wr_ptr] <= push_data;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push_ok) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop_ok) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({push_ok, pop_ok})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/sigdel_event_builder.sv
// rtl/sigdel_event_builder.sv - sigdel event builder top; SIGDEL_PILEUP_EN enables pile-up flagging
module sigdel_event_builder
    import sigdel_pkg::*;
#(
    parameter int NTIME      = 2,
    parameter int NENERGY    = 8,
    parameter int SPC        = 8,
    parameter int ID_BITS    = 6,
    parameter int COUNTER    = 17,
    parameter int EBITS      = 12,
    parameter int CRC_BITS   = 5,
    parameter int FIFO_DEPTH = 4,
    parameter int MAX_LEN    = 255,
    localparam int FW        = $clog2(SPC),
    localparam int MA_BITS   = $clog2(NENERGY) + 1,
    localparam int TIME_BITS = COUNTER + FW,
    localparam int DATA_BITS = CRC_BITS + 1 + ID_BITS + NENERGY*EBITS + TIME_BITS,
    localparam int LEN_BITS  = $clog2(MAX_LEN + 1)
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [ID_BITS-1:0]       block_id,
    input  logic [NTIME*SPC-1:0]     samples_t,
    input  logic [NENERGY*SPC-1:0]   samples_e,
    input  logic [COUNTER-1:0]       counter,
    input  logic [PERIOD_BITS-1:0]   period,
    input  logic                     period_done,
    input  logic [MA_BITS-1:0]       min_active,
    output logic                     stall,
    input  logic                     data_ready,
    output logic                     data_valid,
    output logic [DATA_BITS-1:0]     data_out,
    output logic [PERIOD_BITS-1:0]   period_out,
    output logic [STAT_BITS-1:0]     drop_count,
    output logic [STAT_BITS-1:0]     timeout_count
);

    logic [1:0]               state;
    logic                     e_prev;
    logic [NTIME-1:0]         t_prev;
    logic [NENERGY*EBITS-1:0] sums;
    logic [NENERGY-1:0]       fired;
    logic [LEN_BITS-1:0]      len;
    logic                     time_valid;
    logic [TIME_BITS-1:0]     time_stamp;
    logic [PERIOD_BITS-1:0]   period_tag;

    logic                     e_any;
    logic                     quiet;
    logic [NENERGY-1:0]       e_ch;
    logic [NENERGY*EBITS-1:0] sums_load;
    logic [NENERGY*EBITS-1:0] sums_acc;
    logic [NTIME-1:0]         t_now;
    logic [NTIME-1:0]         t_rise;
    logic [NTIME*FW-1:0]      fine_ch;
    logic [FW-1:0]            fine_min;
    logic [5:0]               fired_cnt;
    logic                     event_ok;
    logic                     close;
    logic                     timeout;
    logic                     start;
    logic                     end_event;
    logic                     to_idle;
    logic                     latch_now;
    logic                     single;
    logic                     push;
    logic                     pop;
    logic                     fifo_full;
    logic                     fifo_empty;
    logic [DATA_BITS+PERIOD_BITS-1:0] fifo_wdata;
    logic [DATA_BITS+PERIOD_BITS-1:0] fifo_rdata;

    for (genvar c = 0; c < NENERGY; c++) begin : g_energy
        logic [5:0]     pc;
        logic [EBITS:0] acc;
        assign e_ch[c] = |samples_e[c*SPC +: SPC];
        assign pc      = popcount32(32'(samples_e[c*SPC +: SPC]));
        assign acc     = {1'b0, sums[c*EBITS +: EBITS]} + (EBITS+1)'(pc);
        assign sums_acc[c*EBITS +: EBITS]  = acc[EBITS] ? {EBITS{1'b1}} : acc[EBITS-1:0];
        assign sums_load[c*EBITS +: EBITS] = EBITS'(pc);
    end

    for (genvar c = 0; c < NTIME; c++) begin : g_timing
        assign t_now[c]            = |samples_t[c*SPC +: SPC];
        assign fine_ch[c*FW +: FW] = FW'(fine_index(32'(samples_t[c*SPC +: SPC]), SPC));
    end

    assign t_rise = t_now & ~t_prev;
    assign e_any  = |e_ch;
    assign quiet  = !e_any && !e_prev;

    always_comb begin
        fine_min = {FW{1'b1}};
        for (int c = 0; c < NTIME; c++) begin
            if (t_rise[c] && (fine_ch[c*FW +: FW] < fine_min)) begin
                fine_min = fine_ch[c*FW +: FW];
            end
        end
    end

    assign fired_cnt = popcount32(32'(fired));
    assign event_ok  = time_valid && ((min_active == '0) || (int'(fired_cnt) >= int'(min_active)));
    assign close     = (state == ST_ACTIVE) && quiet;
    assign timeout   = (state == ST_ACTIVE) && !quiet && (len == LEN_BITS'(MAX_LEN));
    assign start     = (state == ST_IDLE) && e_any;
    assign end_event = close || timeout;
    assign to_idle   = (state != ST_IDLE) && quiet;
    assign latch_now = ((state == ST_IDLE) || (state == ST_ACTIVE)) && (|t_rise) && !time_valid;
    assign push      = close && event_ok;
    assign pop       = data_valid && data_ready;

`ifdef SIGDEL_PILEUP_EN
    logic pileup;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            pileup <= 1'b0;
        end else if (end_event) begin
            pileup <= 1'b0;
        end else if ((state == ST_ACTIVE) && time_valid && (|t_rise)) begin
            pileup <= 1'b1;
        end
    end

    assign single = !pileup;
`else
    assign single = 1'b1;
`endif

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state         <= ST_IDLE;
            e_prev        <= 1'b0;
            t_prev        <= '0;
            sums          <= '0;
            fired         <= '0;
            len           <= '0;
            time_valid    <= 1'b0;
            time_stamp    <= '0;
            period_tag    <= '0;
            stall         <= 1'b0;
            drop_count    <= '0;
            timeout_count <= '0;
        end else begin
            e_prev <= e_any;
            t_prev <= t_now;

            case (state)
                ST_IDLE: begin
                    if (e_any) begin
                        state <= ST_ACTIVE;
                        sums  <= sums_load;
                        fired <= e_ch;
                        len   <= LEN_BITS'(1);
                    end
                end
                ST_ACTIVE: begin
                    if (quiet) begin
                        state <= ST_IDLE;
                    end else if (timeout) begin
                        state <= ST_QUIET;
                        if (timeout_count != '1) begin
                            timeout_count <= timeout_count + 1'b1;
                        end
                    end else begin
                        sums  <= sums_acc;
                        fired <= fired | e_ch;
                        len   <= len + 1'b1;
                    end
                end
                ST_QUIET: begin
                    if (quiet) begin
                        state <= ST_IDLE;
                    end
                end
                default: state <= ST_IDLE;
            endcase

            // A finished or aborted event releases its time stamp for the next one.
            if (end_event) begin
                time_valid <= 1'b0;
            end else if (latch_now) begin
                time_valid <= 1'b1;
                time_stamp <= {counter, fine_min};
                period_tag <= period;
            end

            if (to_idle) begin
                stall <= 1'b0;
            end else if (period_done && ((state != ST_IDLE) || start)) begin
                stall <= 1'b1;
            end

            if (push && fifo_full && !pop && (drop_count != '1)) begin
                drop_count <= drop_count + 1'b1;
            end
        end
    end

    assign fifo_wdata = {{CRC_BITS{1'b1}}, single, block_id, sums, time_stamp, period_tag};

    sigdel_event_fifo #(
        .WIDTH (DATA_BITS + PERIOD_BITS),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk       (clk),
        .rst       (rst),
        .push      (push),
        .push_data (fifo_wdata),
        .pop       (pop),
        .pop_data  (fifo_rdata),
        .full      (fifo_full),
        .empty     (fifo_empty)
    );

    assign data_valid = !fifo_empty;
    assign data_out   = fifo_rdata[PERIOD_BITS +: DATA_BITS];
    assign period_out = fifo_rdata[PERIOD_BITS-1:0];

endmodule

// File: tb/tb_sigdel_event_builder.sv
// tb/tb_sigdel_event_builder.sv - scoreboard bench for sigdel_event_builder at default parameters
module tb_sigdel_event_builder;

    localparam logic [5:0] BID = 6'h2A;

    logic          clk = 1'b0;
    logic          rst;
    logic [5:0]    block_id;
    logic [15:0]   samples_t;
    logic [63:0]   samples_e;
    logic [16:0]   counter;
    logic [47:0]   period;
    logic          period_done;
    logic [3:0]    min_active;
    logic          stall;
    logic          data_ready;
    logic          data_valid;
    logic [127:0]  data_out;
    logic [47:0]   period_out;
    logic [15:0]   drop_count;
    logic [15:0]   timeout_count;

    typedef struct {
        logic [127:0] d;
        logic [47:0]  p;
    } exp_t;

    exp_t exp_q[$];
    exp_t mon_e;
    int   checks = 0;
    int   passes = 0;

    always #5 clk = ~clk;

    sigdel_event_builder dut (
        .clk           (clk),
        .rst           (rst),
        .block_id      (block_id),
        .samples_t     (samples_t),
        .samples_e     (samples_e),
        .counter       (counter),
        .period        (period),
        .period_done   (period_done),
        .min_active    (min_active),
        .stall         (stall),
        .data_ready    (data_ready),
        .data_valid    (data_valid),
        .data_out      (data_out),
        .period_out    (period_out),
        .drop_count    (drop_count),
        .timeout_count (timeout_count)
    );

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] req);
        checks++;
        if (act === req) passes++;
        else $display("FAIL %s actual=%h required=%h", name, act, req);
    endtask

    function automatic logic [127:0] mk(input logic [95:0] s, input logic [16:0] cnt,
                                        input logic [2:0] fine, input logic flag);
        return {5'b11111, flag, BID, s, cnt, fine};
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic expect_word(input logic [127:0] d, input logic [47:0] p);
        exp_t e;
        e.d = d;
        e.p = p;
        exp_q.push_back(e);
    endtask

    task automatic send_event(input logic [15:0] t, input logic [63:0] e, input int n,
                              input logic [16:0] cnt, input logic [47:0] per);
        counter   = cnt;
        period    = per;
        samples_t = t;
        samples_e = e;
        repeat (n) tick();
        samples_t = '0;
        samples_e = '0;
        repeat (3) tick();
    endtask

    task automatic wait_drain(input string name);
        for (int i = 0; i < 100 && exp_q.size() != 0; i++) tick();
        check(name, 128'(exp_q.size()), 128'd0);
    endtask

    // Monitor: every accepted handshake must match the head of the scoreboard.
    initial begin
        forever begin
            @(negedge clk);
            if (rst && data_valid && data_ready) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    $display("FAIL unexpected_word actual=%h required=none", data_out);
                end else begin
                    mon_e = exp_q.pop_front();
                    check("word_data", data_out, mon_e.d);
                    check("word_period", 128'(period_out), 128'(mon_e.p));
                end
            end
        end
    end

    initial begin
        rst         = 1'b0;
        block_id    = BID;
        samples_t   = '0;
        samples_e   = '0;
        counter     = '0;
        period      = '0;
        period_done = 1'b0;
        min_active  = 4'd8;
        data_ready  = 1'b1;
        repeat (3) tick();
        check("reset_valid", 128'(data_valid), 128'd0);
        check("reset_data", data_out, 128'd0);
        check("reset_period", 128'(period_out), 128'd0);
        check("reset_drop", 128'(drop_count), 128'd0);
        check("reset_timeout", 128'(timeout_count), 128'd0);
        check("reset_stall", 128'(stall), 128'd0);
        rst = 1'b1;
        tick();

        // all channels 0xFF for 3 clocks, timing ch0 0x20
        expect_word(mk({8{12'd24}}, 17'd100, 3'd2, 1'b1), 48'h0000_1234_0001);
        send_event(16'h0020, {8{8'hFF}}, 3, 17'd100, 48'h0000_1234_0001);
        wait_drain("drain_basic");

        // coincidence: four channels fire
        min_active = 4'd5;
        send_event(16'h0020, 64'h0000_0000_0F0F_0F0F, 1, 17'd200, 48'h2);
        check("coinc_reject_valid", 128'(data_valid), 128'd0);
        min_active = 4'd4;
        expect_word(mk({{4{12'd0}}, {4{12'd4}}}, 17'd201, 3'd2, 1'b1), 48'h3);
        send_event(16'h0020, 64'h0000_0000_0F0F_0F0F, 1, 17'd201, 48'h3);
        wait_drain("drain_coinc");

        // backpressure: five events into a four-deep buffer, fine time varies
        min_active = 4'd8;
        data_ready = 1'b0;
        for (int i = 0; i < 5; i++) begin
            logic [7:0] tb;
            tb = 8'h80 >> i;
            if (i < 4) expect_word(mk({8{12'd2}}, 17'(300 + i), 3'(i), 1'b1), 48'(16 + i));
            send_event({tb, 8'h00}, {8{8'h01}}, 2, 17'(300 + i), 48'(16 + i));
        end
        check("drop_count", 128'(drop_count), 128'd1);
        check("full_valid", 128'(data_valid), 128'd1);
        data_ready = 1'b1;
        wait_drain("drain_backpressure");

        // timeout: energy active for 300 clocks
        counter   = 17'd350;
        samples_t = 16'h0020;
        samples_e = {8{8'hFF}};
        for (int i = 0; i < 300; i++) begin
            period_done = (i == 10);
            tick();
            if (i == 20) check("stall_active", 128'(stall), 128'd1);
            if (i == 280) check("stall_quiet_state", 128'(stall), 128'd1);
        end
        period_done = 1'b0;
        samples_t   = '0;
        samples_e   = '0;
        repeat (3) tick();
        check("timeout_count", 128'(timeout_count), 128'd1);
        check("stall_cleared", 128'(stall), 128'd0);
        check("timeout_no_word", 128'(data_valid), 128'd0);

        // second timing rising edge inside one event
`ifdef SIGDEL_PILEUP_EN
        expect_word(mk({8{12'd32}}, 17'd400, 3'd2, 1'b0), 48'h5);
`else
        expect_word(mk({8{12'd32}}, 17'd400, 3'd2, 1'b1), 48'h5);
`endif
        counter   = 17'd400;
        period    = 48'h5;
        samples_e = {8{8'hFF}};
        samples_t = 16'h0020;
        tick();
        samples_t = 16'h0000;
        counter   = 17'd401;
        tick();
        samples_t = 16'h0010;
        tick();
        tick();
        samples_t = '0;
        samples_e = '0;
        repeat (3) tick();
        wait_drain("drain_pileup");

        // reset in the middle of an event with two words buffered
        data_ready = 1'b0;
        send_event(16'h0020, {8{8'hFF}}, 1, 17'd450, 48'h6);
        send_event(16'h0020, {8{8'hFF}}, 1, 17'd451, 48'h7);
        check("prereset_valid", 128'(data_valid), 128'd1);
        samples_t   = 16'h0020;
        samples_e   = {8{8'hFF}};
        period_done = 1'b1;
        tick();
        period_done = 1'b0;
        tick();
        check("prereset_stall", 128'(stall), 128'd1);
        #2;
        rst = 1'b0;
        #1;
        check("midreset_valid", 128'(data_valid), 128'd0);
        check("midreset_drop", 128'(drop_count), 128'd0);
        check("midreset_timeout", 128'(timeout_count), 128'd0);
        check("midreset_stall", 128'(stall), 128'd0);
        samples_t = '0;
        samples_e = '0;
        tick();
        tick();
        rst        = 1'b1;
        data_ready = 1'b1;
        tick();
        expect_word(mk({8{12'd16}}, 17'd500, 3'd2, 1'b1), 48'h8);
        send_event(16'h0020, {8{8'hFF}}, 2, 17'd500, 48'h8);
        wait_drain("drain_after_reset");

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
